// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory port between instruction
// fetch and load/store, steers sub-word stores onto byte lanes and
// extracts/extends sub-word loads on the one-cycle-delayed return path.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifetch_req,
  input  logic [29:0] ifetch_addr,
  output logic        ifetch_gnt,
  output logic        ifetch_valid,
  output logic [31:0] ifetch_data,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [1:0]  data_size,
  input  logic        data_unsigned,
  output logic        data_gnt,
  output logic        data_valid,
  output logic [31:0] data_rdata,
  output logic        data_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_FETCH = 2'd1;
  localparam logic [1:0] OWN_DATA  = 2'd2;
  localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);

  logic [3:0]  starve_cnt;
  logic [1:0]  rsp_owner;
  logic [1:0]  rsp_owner_next;
  logic [1:0]  rsp_size;
  logic [1:0]  rsp_off;
  logic        rsp_unsigned;
  logic        rsp_err;
  logic        rsp_we;
  logic        is_half;
  logic        is_word;
  logic        misaligned;
  logic        data_win;
  logic        fetch_win;
  logic [31:0] lane;
  logic [31:0] load_ext;

  // Decode access size and flag accesses that cross their natural alignment
  always_comb begin
    is_half    = (data_size == 2'b01);
    is_word    = data_size[1];
    misaligned = (is_half && data_addr[0]) ||
                 (is_word && (data_addr[1:0] != 2'b00));
  end

  // Data has priority unless fetch has already waited STARVE_LIMIT data grants
  always_comb begin
    data_win  = !rst && data_req && !(ifetch_req && (starve_cnt == LIMIT));
    fetch_win = !rst && ifetch_req && !data_win;
  end

  assign data_gnt   = data_win;
  assign ifetch_gnt = fetch_win;

  // Drive the memory port from the winner; misaligned data issues no access
  always_comb begin
    mem_addr  = {ifetch_addr, 2'b00};
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_wdata = 32'h0;
    if (data_win) begin
      mem_addr = {data_addr[31:2], 2'b00};
      if (!misaligned) begin
        if (data_we) begin
          mem_we = 1'b1;
          case (data_size)
            2'b00: begin
              mem_be    = 4'b0001 << data_addr[1:0];
              mem_wdata = {4{data_wdata[7:0]}};
            end
            2'b01: begin
              mem_be    = 4'b0011 << data_addr[1:0];
              mem_wdata = {2{data_wdata[15:0]}};
            end
            default: begin
              mem_be    = 4'b1111;
              mem_wdata = data_wdata;
            end
          endcase
        end else begin
          mem_be = 4'b1111;
        end
      end
    end
  end

  // Count consecutive data grants taken while fetch is waiting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (fetch_win || !ifetch_req) begin
      starve_cnt <= 4'd0;
    end else if (data_win && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Owner of next cycle's read response
  always_comb begin
    rsp_owner_next = OWN_NONE;
    if (data_win) begin
      rsp_owner_next = OWN_DATA;
    end else if (fetch_win) begin
      rsp_owner_next = OWN_FETCH;
    end
  end

  // Capture response ownership and the data access attributes at grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_owner    <= OWN_NONE;
      rsp_size     <= 2'b00;
      rsp_off      <= 2'b00;
      rsp_unsigned <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_we       <= 1'b0;
    end else begin
      rsp_owner <= rsp_owner_next;
      if (data_win) begin
        rsp_size     <= data_size;
        rsp_off      <= data_addr[1:0];
        rsp_unsigned <= data_unsigned;
        rsp_err      <= misaligned;
        rsp_we       <= data_we;
      end
    end
  end

  // Select the addressed lane and extend it to 32 bits
  always_comb begin
    lane = mem_rdata >> {rsp_off, 3'b000};
    case (rsp_size)
      2'b00:   load_ext = {{24{!rsp_unsigned && lane[7]}}, lane[7:0]};
      2'b01:   load_ext = {{16{!rsp_unsigned && lane[15]}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  assign ifetch_valid = (rsp_owner == OWN_FETCH);
  assign ifetch_data  = ifetch_valid ? mem_rdata : 32'h0;
  assign data_valid   = (rsp_owner == OWN_DATA);
  assign data_err     = data_valid && rsp_err;
  assign data_rdata   = (data_valid && !rsp_err && !rsp_we) ? load_ext : 32'h0;

endmodule
